// File: rtl/can_bt_pkg.sv
// Shared encodings and default widths for the CAN bit-timing blocks.
// Used by the quantum counter, the bit-timing FSM and the bench.
package can_bt_pkg;

    localparam int CNT_W_DEF   = 5;
    localparam int TSEG1_W_DEF = 4;
    localparam int TSEG2_W_DEF = 3;
    localparam int SJW_W_DEF   = 2;

    typedef enum logic [1:0] {
        TSEG_HOLD        = 2'b00,
        TSEG_LOAD        = 2'b01,
        TSEG_STRETCH_ERR = 2'b10,
        TSEG_STRETCH_SJW = 2'b11
    } tseg_cmd_e;

    // 11 is unused by the FSM and treated as hold
    typedef enum logic [1:0] {
        SMPL_HOLD    = 2'b00,
        SMPL_SET_REC = 2'b01,
        SMPL_SAMPLE  = 2'b10,
        SMPL_RSVD    = 2'b11
    } smpl_cmd_e;

endpackage

// File: rtl/bittime_count_cmp.sv
// Comparator bank: the six flags the bit-timing FSM branches on.
// Widened by one bit so t1e+tseg2+2 and count+sjw cannot wrap.
module bt_cmp
    import can_bt_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TSEG2_W = TSEG2_W_DEF,
    parameter int SJW_W   = SJW_W_DEF
) (
    input  logic [CNT_W-1:0]   count,
    input  logic [CNT_W-1:0]   t1e,
    input  logic [TSEG2_W-1:0] tseg2,
    input  logic [SJW_W-1:0]   sjw,
    output logic               notnull,
    output logic               gtsjwp1,
    output logic               gttseg1p1,
    output logic               cpsgetseg1ptseg2p2,
    output logic               cetseg1ptseg2p1,
    output logic               countesmpltime
);

    localparam int XW = CNT_W + 1;

    logic [XW-1:0] count_x;
    logic [XW-1:0] t1e_x;
    logic [XW-1:0] tseg2_x;
    logic [XW-1:0] sjw_x;
    logic [XW-1:0] sample_pt;
    logic [XW-1:0] bit_end;

    assign count_x   = XW'(count);
    assign t1e_x     = XW'(t1e);
    assign tseg2_x   = XW'(tseg2);
    assign sjw_x     = XW'(sjw);
    assign sample_pt = t1e_x + XW'(1);
    assign bit_end   = t1e_x + tseg2_x + XW'(1);

    assign notnull            = (count_x != '0);
    assign gtsjwp1            = (count_x > (sjw_x + XW'(1)));
    assign gttseg1p1          = (count_x > sample_pt);
    assign countesmpltime     = (count_x == sample_pt);
    assign cetseg1ptseg2p1    = (count_x == bit_end);
    assign cpsgetseg1ptseg2p2 = ((count_x + sjw_x) >= (bit_end + XW'(1)));

endmodule

// File: rtl/bittime_count.sv
// Time-quantum counter, resync-adjusted TSEG1 register, sampled bit and
// edge buffer; every state update is qualified by the prescaler strobe.
module bittime_count
    import can_bt_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TSEG1_W = TSEG1_W_DEF,
    parameter int TSEG2_W = TSEG2_W_DEF,
    parameter int SJW_W   = SJW_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               Prescale_EN,
    input  logic               rx,
    input  logic [TSEG1_W-1:0] tseg1,
    input  logic [TSEG2_W-1:0] tseg2,
    input  logic [SJW_W-1:0]   sjw,
    input  logic               increment,
    input  logic               setctzero,
    input  logic               setctotwo,
    input  logic [1:0]         tseg_reg_ctrl,
    input  logic [1:0]         smpldbit_reg_ctrl,
    output logic               notnull,
    output logic               gtsjwp1,
    output logic               gttseg1p1,
    output logic               cpsgetseg1ptseg2p2,
    output logic               cetseg1ptseg2p1,
    output logic               countesmpltime,
    output logic               puffer,
    output logic               smpldbit,
    output logic [CNT_W-1:0]   count
);

    localparam int               XW      = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] t1e_reg, t1e_next;
    logic             smpldbit_reg, smpldbit_next;
    logic             puffer_reg, puffer_next;

    logic [XW-1:0]    t1e_addend;
    logic [XW-1:0]    t1e_sum;
    logic [CNT_W-1:0] t1e_sat;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg    <= '0;
            t1e_reg      <= '0;
            smpldbit_reg <= 1'b1;
            puffer_reg   <= 1'b1;
        end else begin
            count_reg    <= count_next;
            t1e_reg      <= t1e_next;
            smpldbit_reg <= smpldbit_next;
            puffer_reg   <= puffer_next;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (Prescale_EN) begin
            if (setctzero) begin
                count_next = '0;
            end else if (setctotwo) begin
                count_next = CNT_TWO;
            end else if (increment && (count_reg != CNT_MAX)) begin
                count_next = count_reg + CNT_W'(1);
            end
        end
    end

    // Phase error is count-2 measured on the pre-update count; below 2 it is zero
    always_comb begin
        t1e_addend = '0;
        case (tseg_reg_ctrl)
            TSEG_STRETCH_ERR: begin
                if (count_reg >= CNT_TWO) begin
                    t1e_addend = XW'(count_reg - CNT_TWO);
                end
            end
            TSEG_STRETCH_SJW: t1e_addend = XW'(sjw);
            default:          t1e_addend = '0;
        endcase
    end

    assign t1e_sum = XW'(t1e_reg) + t1e_addend;
    assign t1e_sat = t1e_sum[CNT_W] ? CNT_MAX : t1e_sum[CNT_W-1:0];

    always_comb begin
        t1e_next = t1e_reg;
        if (Prescale_EN) begin
            case (tseg_reg_ctrl)
                TSEG_LOAD:        t1e_next = CNT_W'(tseg1);
                TSEG_STRETCH_ERR: t1e_next = t1e_sat;
                TSEG_STRETCH_SJW: t1e_next = t1e_sat;
                default:          t1e_next = t1e_reg;
            endcase
        end
    end

    always_comb begin
        smpldbit_next = smpldbit_reg;
        puffer_next   = puffer_reg;
        if (Prescale_EN) begin
            puffer_next = rx;
            case (smpldbit_reg_ctrl)
                SMPL_SET_REC: smpldbit_next = 1'b1;
                SMPL_SAMPLE:  smpldbit_next = rx;
                default:      smpldbit_next = smpldbit_reg;
            endcase
        end
    end

    bt_cmp #(
        .CNT_W   (CNT_W),
        .TSEG2_W (TSEG2_W),
        .SJW_W   (SJW_W)
    ) u_cmp (
        .count              (count_reg),
        .t1e                (t1e_reg),
        .tseg2              (tseg2),
        .sjw                (sjw),
        .notnull            (notnull),
        .gtsjwp1            (gtsjwp1),
        .gttseg1p1          (gttseg1p1),
        .cpsgetseg1ptseg2p2 (cpsgetseg1ptseg2p2),
        .cetseg1ptseg2p1    (cetseg1ptseg2p1),
        .countesmpltime     (countesmpltime)
    );

    assign count    = count_reg;
    assign smpldbit = smpldbit_reg;
    assign puffer   = puffer_reg;

endmodule

// File: tb/tb_bittime_count.sv
// Bench for bittime_count: integer reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_bittime_count;
    import can_bt_pkg::*;

    localparam int CNT_W   = CNT_W_DEF;
    localparam int TSEG1_W = TSEG1_W_DEF;
    localparam int TSEG2_W = TSEG2_W_DEF;
    localparam int SJW_W   = SJW_W_DEF;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               Prescale_EN;
    logic               rx;
    logic [TSEG1_W-1:0] tseg1;
    logic [TSEG2_W-1:0] tseg2;
    logic [SJW_W-1:0]   sjw;
    logic               increment, setctzero, setctotwo;
    logic [1:0]         tseg_reg_ctrl, smpldbit_reg_ctrl;
    logic notnull, gtsjwp1, gttseg1p1, cpsgetseg1ptseg2p2, cetseg1ptseg2p1, countesmpltime;
    logic puffer, smpldbit;
    logic [CNT_W-1:0]   count;

    int checks = 0;
    int errors = 0;

    int m_count = 0, m_t1e = 0, m_smpl = 1, m_puf = 1;
    bit m_valid = 1'b0;

    bittime_count #(
        .CNT_W(CNT_W), .TSEG1_W(TSEG1_W), .TSEG2_W(TSEG2_W), .SJW_W(SJW_W)
    ) dut (
        .clock(clk), .reset(reset), .Prescale_EN(Prescale_EN), .rx(rx),
        .tseg1(tseg1), .tseg2(tseg2), .sjw(sjw),
        .increment(increment), .setctzero(setctzero), .setctotwo(setctotwo),
        .tseg_reg_ctrl(tseg_reg_ctrl), .smpldbit_reg_ctrl(smpldbit_reg_ctrl),
        .notnull(notnull), .gtsjwp1(gtsjwp1), .gttseg1p1(gttseg1p1),
        .cpsgetseg1ptseg2p2(cpsgetseg1ptseg2p2), .cetseg1ptseg2p1(cetseg1ptseg2p1),
        .countesmpltime(countesmpltime), .puffer(puffer), .smpldbit(smpldbit),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    // Reference: what one strobe does to the bit-timing state, in plain integers
    always @(posedge clk) begin
        int nc, nt, ns, np;
        nc = m_count; nt = m_t1e; ns = m_smpl; np = m_puf;
        if (reset) begin
            nc = 0; nt = 0; ns = 1; np = 1;
        end else if (Prescale_EN) begin
            if (setctzero)      nc = 0;
            else if (setctotwo) nc = 2;
            else if (increment) nc = imin(m_count + 1, CMAX);
            case (tseg_reg_ctrl)
                2'b01: nt = int'(tseg1);
                2'b10: nt = imin(m_t1e + ((m_count >= 2) ? m_count - 2 : 0), CMAX);
                2'b11: nt = imin(m_t1e + int'(sjw), CMAX);
                default: ;
            endcase
            if (smpldbit_reg_ctrl == 2'b01)      ns = 1;
            else if (smpldbit_reg_ctrl == 2'b10) ns = int'(rx);
            np = int'(rx);
        end
        m_count <= nc; m_t1e <= nt; m_smpl <= ns; m_puf <= np;
        m_valid <= 1'b1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            int t2, sj;
            t2 = int'(tseg2); sj = int'(sjw);
            chk("m_count",    int'(count),              m_count);
            chk("m_smpldbit", int'(smpldbit),           m_smpl);
            chk("m_puffer",   int'(puffer),             m_puf);
            chk("m_notnull",  int'(notnull),            int'(m_count != 0));
            chk("m_gtsjwp1",  int'(gtsjwp1),            int'(m_count > sj + 1));
            chk("m_gttseg1p1", int'(gttseg1p1),         int'(m_count > m_t1e + 1));
            chk("m_cest",     int'(countesmpltime),     int'(m_count == m_t1e + 1));
            chk("m_cet",      int'(cetseg1ptseg2p1),    int'(m_count == m_t1e + t2 + 1));
            chk("m_cps",      int'(cpsgetseg1ptseg2p2), int'(m_count + sj >= m_t1e + t2 + 2));
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse();
        Prescale_EN = 1'b1;
        @(posedge clk);
        #2;
        Prescale_EN = 1'b0;
        $display("strobe: cmd inc=%0b z=%0b two=%0b tseg=%0d smpl=%0d rx=%0b -> count=%0d smpldbit=%0b puffer=%0b cest=%0b",
                 increment, setctzero, setctotwo, tseg_reg_ctrl, smpldbit_reg_ctrl, rx,
                 count, smpldbit, puffer, countesmpltime);
    endtask

    task automatic set_cmd(input bit inc, input bit z, input bit two,
                           input logic [1:0] tc, input logic [1:0] sc);
        increment = inc; setctzero = z; setctotwo = two;
        tseg_reg_ctrl = tc; smpldbit_reg_ctrl = sc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; Prescale_EN = 1'b0; rx = 1'b1;
        tseg1 = 4'd5; tseg2 = 3'd1; sjw = 2'd3;
        set_cmd(0, 0, 0, TSEG_HOLD, SMPL_HOLD);
        wait_clk(2);
        chk("rst_count", int'(count), 0);
        chk("rst_smpldbit", int'(smpldbit), 1);
        chk("rst_puffer", int'(puffer), 1);
        chk("rst_notnull", int'(notnull), 0);
        chk("rst_cps_sjw3_t2_1", int'(cpsgetseg1ptseg2p2), 1);
        tseg2 = 3'd3; #1;
        chk("rst_cps_sjw3_t2_3", int'(cpsgetseg1ptseg2p2), 0);
        sjw = 2'd2;
        reset = 1'b0;
        wait_clk(1);

        // Reload and count
        set_cmd(0, 0, 0, TSEG_LOAD, SMPL_HOLD); pulse();
        set_cmd(1, 0, 0, TSEG_HOLD, SMPL_HOLD);
        for (int k = 1; k <= 9; k++) begin
            pulse();
            chk("cnt_step", int'(count), k);
            chk("cnt_cest", int'(countesmpltime), int'(k == 6));
            chk("cnt_cet", int'(cetseg1ptseg2p1), int'(k == 9));
        end

        // Strobe gating with increment held high
        for (int i = 0; i < 3; i++) begin
            wait_clk(3);
            chk("gate_hold", int'(count), 9 + i);
            pulse();
            chk("gate_step", int'(count), 10 + i);
        end

        // Phase-error stretch: t1e 5 -> 7 at count 4
        set_cmd(0, 1, 0, TSEG_LOAD, SMPL_HOLD); pulse();
        set_cmd(1, 0, 0, TSEG_HOLD, SMPL_HOLD);
        repeat (4) pulse();
        chk("err_count4", int'(count), 4);
        set_cmd(0, 0, 0, TSEG_STRETCH_ERR, SMPL_HOLD); pulse();
        chk("err_count_held", int'(count), 4);
        set_cmd(1, 0, 0, TSEG_HOLD, SMPL_HOLD);
        repeat (2) pulse();
        chk("err_cest_at6", int'(countesmpltime), 0);
        repeat (2) pulse();
        chk("err_cest_at8", int'(countesmpltime), 1);

        // SJW stretch: t1e 5 -> 8, sample point at 9
        sjw = 2'd3;
        set_cmd(0, 1, 0, TSEG_LOAD, SMPL_HOLD); pulse();
        set_cmd(0, 0, 0, TSEG_STRETCH_SJW, SMPL_HOLD); pulse();
        set_cmd(1, 0, 0, TSEG_HOLD, SMPL_HOLD);
        repeat (9) pulse();
        chk("sjw_cest_at9", int'(countesmpltime), 1);

        // Saturation: t1e 15 -> 30 -> 31, count saturates at 31
        tseg1 = 4'd15;
        set_cmd(0, 1, 0, TSEG_LOAD, SMPL_HOLD); pulse();
        set_cmd(0, 0, 0, TSEG_STRETCH_SJW, SMPL_HOLD);
        repeat (5) pulse();
        set_cmd(1, 0, 0, TSEG_HOLD, SMPL_HOLD);
        repeat (31) pulse();
        chk("sat_count31", int'(count), 31);
        chk("sat_cest_t1e30", int'(countesmpltime), 1);
        set_cmd(0, 0, 0, TSEG_STRETCH_SJW, SMPL_HOLD); pulse();
        chk("sat_cest_t1e31", int'(countesmpltime), 0);
        set_cmd(1, 0, 0, TSEG_HOLD, SMPL_HOLD); pulse();
        chk("sat_count_hold", int'(count), 31);

        // Command priority
        set_cmd(1, 1, 1, TSEG_HOLD, SMPL_HOLD); pulse();
        chk("prio_zero", int'(count), 0);
        set_cmd(1, 0, 1, TSEG_HOLD, SMPL_HOLD); pulse();
        chk("prio_two", int'(count), 2);

        // Sampled bit and edge buffer
        rx = 1'b0;
        set_cmd(0, 0, 0, TSEG_HOLD, SMPL_SAMPLE); pulse();
        chk("smpl_rx0", int'(smpldbit), 0);
        set_cmd(0, 0, 0, TSEG_HOLD, SMPL_SET_REC); pulse();
        chk("smpl_setrec", int'(smpldbit), 1);
        set_cmd(0, 0, 0, TSEG_HOLD, SMPL_HOLD);
        rx = 1'b1; pulse();
        chk("puf_high", int'(puffer), 1);
        rx = 1'b0; #1;
        chk("puf_edge", int'(puffer), 1);
        pulse();
        chk("puf_low", int'(puffer), 0);

        // Reset mid-bit discards the stretch
        tseg1 = 4'd5;
        set_cmd(0, 1, 0, TSEG_LOAD, SMPL_HOLD); pulse();
        set_cmd(1, 0, 0, TSEG_HOLD, SMPL_HOLD);
        repeat (4) pulse();
        set_cmd(0, 0, 0, TSEG_STRETCH_ERR, SMPL_SAMPLE); pulse();
        chk("mid_smpl0", int'(smpldbit), 0);
        set_cmd(0, 0, 0, TSEG_HOLD, SMPL_HOLD);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_smpl", int'(smpldbit), 1);
        chk("mid_rst_puf", int'(puffer), 1);
        set_cmd(1, 0, 0, TSEG_HOLD, SMPL_HOLD); pulse();
        chk("mid_rst_t1e0_cest", int'(countesmpltime), 1);
        set_cmd(0, 0, 0, TSEG_HOLD, SMPL_HOLD);

        wait_clk(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
